// File: rtl/can_tx_bit.sv
// can_tx_bit - bit-level CAN transmitter.
//
// Takes one frame bit at a time from the frame builder over a valid/ready
// handshake and drives the TX line for exactly N = clocks-per-bit cycles per
// bit. While `en` is high (SOF..CRC) a complementary stuff bit is inserted
// after every five consecutive identical bits.
//
// Optional feature macro: CAN_TX_STUFF_EN
//   defined   : STUFF state, run tracking and stuff_bit output are built.
//   undefined : no stuffing; en ignored, stuff_bit tied low.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              stuffing region flag, captured with each accepted bit
//   din/din_valid   next bit to send (0 dominant, 1 recessive) and its valid
//   din_ready       combinational: a bit is accepted this cycle if valid
//   tx              registered TX line, idles recessive
//   busy            a data or stuff bit is on the line
//   stuff_bit       the bit currently on tx is a stuff bit
//   bit_start       one-cycle pulse on the first cycle of every bit on tx
module can_tx_bit #(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  output logic tx,
  output logic busy,
  output logic stuff_bit,
  output logic bit_start
);

  localparam int N  = (clk_speed_MHz * 1000) / can_bit_rate_Kbits;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

`ifdef CAN_TX_STUFF_EN
  typedef enum logic [1:0] {IDLE, DATA, STUFF} state_t;
`else
  typedef enum logic {IDLE, DATA} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            bit_start_q, bit_start_d;
  logic            end_of_bit;
  logic            accept;

  assign end_of_bit = (state_q != IDLE) && (cnt_q == CNT_MAX);

`ifdef CAN_TX_STUFF_EN
  logic       stuff_bit_q, stuff_bit_d;
  logic [2:0] run_q, run_d;
  logic       last_q, last_d;
  logic       stuff_pend;

  // Five identical bits were captured with en=1 during this data bit; the
  // stuff bit follows regardless of what upstream offers next.
  assign stuff_pend = (state_q == DATA) && (run_q == 3'd5);
  assign din_ready  = (state_q == IDLE) || (end_of_bit && !stuff_pend);
  assign stuff_bit  = stuff_bit_q;
`else
  logic unused_en;
  assign unused_en = en;
  assign din_ready = (state_q == IDLE) || end_of_bit;
  assign stuff_bit = 1'b0;
`endif

  assign accept = din_valid & din_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    bit_start_d = 1'b0;
`ifdef CAN_TX_STUFF_EN
    stuff_bit_d = stuff_bit_q;
    run_d       = run_q;
    last_d      = last_q;
`endif
    if (state_q != IDLE) cnt_d = cnt_q + 1'b1;

`ifdef CAN_TX_STUFF_EN
    if (end_of_bit && stuff_pend) begin
      // The stuff bit opens a new run of its own polarity.
      state_d     = STUFF;
      cnt_d       = '0;
      tx_d        = ~last_q;
      busy_d      = 1'b1;
      bit_start_d = 1'b1;
      stuff_bit_d = 1'b1;
      last_d      = ~last_q;
      run_d       = 3'd1;
    end else
`endif
    if (accept) begin
      state_d     = DATA;
      cnt_d       = '0;
      tx_d        = din;
      busy_d      = 1'b1;
      bit_start_d = 1'b1;
`ifdef CAN_TX_STUFF_EN
      stuff_bit_d = 1'b0;
      if (!en) begin
        run_d = 3'd0;
      end else if ((din == last_q) && (run_q != 3'd0)) begin
        run_d = run_q + 3'd1;
      end else begin
        run_d  = 3'd1;
        last_d = din;
      end
`endif
    end else if (end_of_bit) begin
      state_d = IDLE;
      cnt_d   = '0;
      tx_d    = 1'b1;
      busy_d  = 1'b0;
`ifdef CAN_TX_STUFF_EN
      stuff_bit_d = 1'b0;
      run_d       = 3'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      bit_start_q <= 1'b0;
`ifdef CAN_TX_STUFF_EN
      stuff_bit_q <= 1'b0;
      run_q       <= 3'd0;
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      bit_start_q <= bit_start_d;
`ifdef CAN_TX_STUFF_EN
      stuff_bit_q <= stuff_bit_d;
      run_q       <= run_d;
      last_q      <= last_d;
`endif
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign bit_start = bit_start_q;

endmodule

// File: tb/tb_can_tx_bit.sv
// Testbench for can_tx_bit at N=100. A line-level model turns the offered
// bit list into the list of bits that must appear on tx (data and stuff),
// and each run is checked cycle by cycle against that list.
module tb_can_tx_bit;

  localparam int N = 100;

  logic clk = 1'b0;
  logic rst_n, en, din, din_valid;
  logic din_ready, tx, busy, stuff_bit, bit_start;

  int total = 0;
  int bad   = 0;

  int bits_a [16];
  int ens_a  [16];
  int line_v [64];
  int line_s [64];
  int line_l;

  can_tx_bit #(.clk_speed_MHz(100), .can_bit_rate_Kbits(1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .tx(tx), .busy(busy), .stuff_bit(stuff_bit),
    .bit_start(bit_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Line model: after five equal bits sent with en=1, the complement is
  // inserted and counts as the first bit of the next run.
  task automatic build(input int nb);
    int prev, run;
    prev = 1; run = 0; line_l = 0;
    for (int i = 0; i < nb; i++) begin
      line_v[line_l] = bits_a[i]; line_s[line_l] = 0; line_l++;
`ifdef CAN_TX_STUFF_EN
      if (ens_a[i] != 0) begin
        if (run > 0 && bits_a[i] == prev) run++;
        else begin run = 1; prev = bits_a[i]; end
      end else run = 0;
      if (run == 5) begin
        prev = 1 - prev;
        line_v[line_l] = prev; line_s[line_l] = 1; line_l++;
        run = 1;
      end
`endif
    end
  endtask

  task automatic run_case(input string nm, input int nb);
    int idx, c, rdy_cnt, slot, ph, nxt_stf;
    bit started, acc, done;
    build(nb);
    idx = 0; c = 0; rdy_cnt = 0; started = 0; done = 0;
    for (int it = 0; it < line_l * N + 20 && !done; it++) begin
      @(negedge clk);
      din_valid = (idx < nb);
      din       = (idx < nb) ? bits_a[idx][0] : 1'b0;
      en        = (idx < nb) ? ens_a[idx][0]  : 1'b0;
      acc       = din_valid && din_ready;
      @(posedge clk);
      if (acc) begin idx++; started = 1; end
      #1;
      if (!started) begin
        if (it > 5) begin
          chk({nm, " start_timeout"}, 0, 1);
          done = 1;
        end
      end else begin
        if (c < line_l * N) begin
          slot = c / N; ph = c % N;
          nxt_stf = (slot + 1 < line_l) ? line_s[slot + 1] : 0;
          chk({nm, " tx"},        int'(tx),        line_v[slot]);
          chk({nm, " stuff_bit"}, int'(stuff_bit), line_s[slot]);
          chk({nm, " bit_start"}, int'(bit_start), (ph == 0) ? 1 : 0);
          chk({nm, " busy"},      int'(busy),      1);
          chk({nm, " din_ready"}, int'(din_ready),
              (ph == N - 1 && nxt_stf == 0) ? 1 : 0);
          if (din_ready) rdy_cnt++;
        end else begin
          chk({nm, " idle_tx"},    int'(tx),        1);
          chk({nm, " idle_busy"},  int'(busy),      0);
          chk({nm, " idle_stuff"}, int'(stuff_bit), 0);
          chk({nm, " idle_rdy"},   int'(din_ready), 1);
          done = 1;
        end
        c++;
      end
    end
    din_valid = 1'b0;
    chk({nm, " all_done"},   int'(done), 1);
    chk({nm, " accepted"},   idx, nb);
    chk({nm, " ready_high"}, rdy_cnt, nb);
    repeat (3) @(posedge clk);
  endtask

  task automatic set_bits(input int n, input int v, input int e, input int base);
    for (int i = 0; i < n; i++) begin
      bits_a[base + i] = v; ens_a[base + i] = e;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; din = 1'b0; din_valid = 1'b0;
    #12;
    chk("rst tx", int'(tx), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst stuff_bit", int'(stuff_bit), 0);
    chk("rst bit_start", int'(bit_start), 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst din_ready", int'(din_ready), 1);

    // Single dominant bit, en=0
    set_bits(1, 0, 0, 0);
    run_case("single", 1);

    // 1,0,1 with en=0
    bits_a[0] = 1; bits_a[1] = 0; bits_a[2] = 1;
    ens_a[0] = 0; ens_a[1] = 0; ens_a[2] = 0;
    run_case("stream101", 3);

    // 0x5,1 with en=1: stuff 1 after the fifth 0
    set_bits(5, 0, 1, 0); set_bits(1, 1, 1, 5);
    build(6);
`ifdef CAN_TX_STUFF_EN
    chk("model len 0x5_1", line_l, 7);
    chk("model stuff pos", line_s[5], 1);
    chk("model stuff val", line_v[5], 1);
    chk("model after stuff", line_v[6], 1);
`else
    chk("model len 0x5_1", line_l, 6);
`endif
    run_case("stuff0", 6);

    // 1x6 with en=1: 11111, stuff 0, 1
    set_bits(6, 1, 1, 0);
    build(6);
`ifdef CAN_TX_STUFF_EN
    chk("model len 1x6", line_l, 7);
    chk("model stuff0 val", line_v[5], 0);
`endif
    run_case("stuff1", 6);

    // 0x5 then 1x4: run continues across the first stuff bit
    set_bits(5, 0, 1, 0); set_bits(4, 1, 1, 5);
    build(9);
`ifdef CAN_TX_STUFF_EN
    chk("model len chain", line_l, 11);
    chk("model chain stuff2", line_s[10], 1);
    chk("model chain val2", line_v[10], 0);
`endif
    run_case("chain", 9);

    // en=0 on the fifth 0: no stuff
    set_bits(4, 0, 1, 0); set_bits(1, 0, 0, 4); set_bits(1, 1, 1, 5);
    build(6);
    chk("model len en_off", line_l, 6);
    run_case("en_off5", 6);

    // en falls after the fifth 0: pending stuff still sent
    set_bits(5, 0, 1, 0); set_bits(1, 1, 0, 5);
    run_case("en_fall", 6);

    // 0x6 with en=1 (stuffed when built with the feature, plain otherwise)
    set_bits(6, 0, 1, 0);
    build(6);
`ifndef CAN_TX_STUFF_EN
    chk("model len 0x6 nostuff", line_l, 6);
`endif
    run_case("zeros6", 6);

    // Asynchronous reset at cnt=40 of a dominant bit
    @(negedge clk); din = 1'b0; en = 1'b0; din_valid = 1'b1;
    @(posedge clk); #1 din_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("pre_rst tx", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst tx", int'(tx), 1);
    chk("async_rst busy", int'(busy), 0);
    chk("async_rst stuff", int'(stuff_bit), 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("post_rst din_ready", int'(din_ready), 1);
    repeat (150) @(posedge clk);
    #1;
    chk("post_rst tx", int'(tx), 1);
    chk("post_rst busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_tx_bit.md
# can_tx_bit

Bit-level CAN transmitter: the transmit-side counterpart of the CAN RX sampler. It accepts one frame bit at a time from the frame-builder over a valid/ready handshake and drives the TX line for exactly one bit period per bit. While `en` is high (SOF through CRC field), it inserts CAN stuff bits after every five consecutive identical bits. It sits between the frame-builder and the transceiver's TXD pin.

## Interface
- `clk_speed_MHz`, default 100: system clock frequency in MHz.
- `can_bit_rate_Kbits`, default 1000: CAN bit rate in kbit/s.
- Derived constant N = (clk_speed_MHz*1000)/can_bit_rate_Kbits: clocks per bit (100 at defaults). The bit counter is $clog2(N) bits wide.

Ports:
- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: stuffing region; sampled with each accepted bit.
- `din` input 1: next bit to send (0 = dominant, 1 = recessive).
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: block accepts `din` this cycle.
- `tx` output 1: registered TX line; idles recessive (1).
- `busy` output 1: a data bit or stuff bit is on the line.
- `stuff_bit` output 1: the current bit on `tx` is a stuff bit.
- `bit_start` output 1: one-clock pulse on the first cycle of each bit on `tx`, including stuff bits.

## Operation
- States: IDLE, DATA, STUFF.
- Bit counter `cnt` runs 0..N-1 in DATA and STUFF, and is held at 0 in IDLE.
- `din_ready` is combinational. It is 1 in IDLE. It is also 1 in DATA or STUFF when `cnt`==N-1 and no stuff bit is pending. Otherwise it is 0.
- Accept means `din_valid & din_ready` at a clock edge. On accept:
  - next state DATA, `cnt` <= 0, `tx` <= `din`, `bit_start` <= 1.
- End of a bit (`cnt`==N-1) with no accept and no stuff pending: next state IDLE, `tx` <= 1, `busy` <= 0.
- Run tracking: registers `last` (1 bit) and `run` (3 bits, 0..5).
  - Bit accepted with `en`=1: if `din`==`last` and `run`>0, then `run`++. Otherwise `run` <= 1 and `last` <= `din`.
  - Bit accepted with `en`=0: `run` <= 0. No stuffing follows it, even if five identical bits preceded it.
  - Entering IDLE clears `run` to 0.
- Stuff pending means `run`==5 during a DATA bit. At that bit's `cnt`==N-1, the next state is STUFF regardless of `din_valid`. Then:
  - `tx` <= ~`last`, `stuff_bit` <= 1, `bit_start` <= 1, `cnt` <= 0.
  - `last` <= ~`last`, `run` <= 1, so the stuff bit starts a new run.
- STUFF lasts N cycles. At its `cnt`==N-1, `din_ready`=1, and it is followed by an accept (DATA) or by IDLE.
- Stuffing is decided by the `en` value captured with the fifth identical bit. If `en` falls afterwards, the pending stuff bit is still sent.
- The block does no arbitration or bus monitoring; `tx` is driven open-loop.

## Timing
- Reset values: `tx`=1, `busy`=0, `stuff_bit`=0, `bit_start`=0, state IDLE, `cnt`=0, `run`=0, `last`=1. `din_ready`=1 once `rst_n` deasserts.
- Latency: a bit accepted at edge k appears on `tx` after edge k. It holds for exactly N cycles (edges k..k+N-1).
- Streaming with `din_valid` held high produces contiguous bits with no gaps. `din_ready` is high for exactly 1 cycle per bit.
- `busy`=1 during every cycle of DATA and STUFF.
- `stuff_bit` is high for exactly N cycles per stuff bit.
- `rst_n` low mid-bit forces all outputs to their reset values immediately (asynchronously). The partial bit is discarded.
- `din_valid` asserted while `din_ready`=0 has no effect. The upstream block holds `din` until accepted.

## Configuration
- `CAN_TX_STUFF_EN` defined: STUFF state, run tracking and `stuff_bit` are compiled in, as described above.
- `CAN_TX_STUFF_EN` undefined:
  - No STUFF state and no run registers.
  - `en` is ignored and `stuff_bit` is tied to 0.
  - `din_ready` is 1 in IDLE and whenever `cnt`==N-1.

## Test plan
Use clk_speed_MHz=100 and can_bit_rate_Kbits=1000 (N=100), with `CAN_TX_STUFF_EN` defined unless noted.
- Reset: `rst_n` low then high -> `tx`=1, `busy`=0, `stuff_bit`=0, `din_ready`=1.
- Single bit: `din`=0 with `en`=0, valid for one cycle -> `tx`=0 for exactly 100 cycles, one `bit_start` pulse, then `tx`=1 and `busy`=0.
- Stream 1,0,1 with `en`=0 -> `tx` shows 1,0,1 at 100 cycles each with no gap. `din_ready` is high 3 times, one cycle each.
- Stuffing, `en`=1:
  - Bits 0,0,0,0,0,1 -> `tx` shows 0 for 500 cycles, then stuff 1 for 100 cycles (`stuff_bit`=1, `din_ready`=0 until its cycle 99), then data 1.
  - Bits 1×6 -> 11111, stuff 0, then 1.
- Run continues across a stuff bit: `en`=1, bits 0×5 then 1×4 -> 00000, stuff 1, 1111, stuff 0 (the first stuff bit counts as run 1).
- `en`=0 on the fifth 0 -> no stuff bit is emitted. Reset asserted at `cnt`=40 of a 0 bit -> `tx`=1 and `busy`=0 immediately.
- Macro undefined: `en`=1 with bits 0×6 -> `tx`=0 for 600 cycles, `stuff_bit` stays 0.
